// File: rtl/frac_div_pkg.sv
// Shared types and constants for the fractional-N divider datapath and its
// period meter; ratio_encode is also used by the divider testbenches.
package frac_div_pkg;

   localparam int unsigned DEF_P_WIDTH = 5;
   localparam int unsigned DEF_S_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_MEASURE,
      ST_OVF
   } meter_state_t;

   // Divide ratio of the dual-modulus divider: p * 2^S + s
   function automatic int unsigned ratio_encode(input int unsigned p, input int unsigned s);
      return (p << DEF_S_WIDTH) + s;
   endfunction

endpackage

// File: rtl/edge_period_counter.sv
// Rising-edge detector on fdiv plus the clk-cycle period counter.
// The counter stops at all-ones so the owner can flag the overflow.
module edge_period_counter #(
   parameter int unsigned CNT_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fdiv,
   input  logic                 clr,
   input  logic                 load,
   input  logic                 inc,
   output logic                 rise,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 cnt_max
);

   logic fdiv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fdiv_q <= 1'b0;
         cnt    <= '0;
      end else begin
         fdiv_q <= fdiv;
         if (clr)
            cnt <= '0;
         else if (load)
            cnt <= CNT_WIDTH'(1);
         else if (inc && !cnt_max)
            cnt <= cnt + CNT_WIDTH'(1);
      end
   end

   assign rise    = fdiv & ~fdiv_q;
   assign cnt_max = &cnt;

endmodule

// File: rtl/div_period_meter.sv
// Measures the clk-cycle period between fdiv rising edges, decodes it into
// the P/S divide fields and reports lock once the ratio repeats.
module div_period_meter
   import frac_div_pkg::*;
#(
   parameter int unsigned P_WIDTH   = DEF_P_WIDTH,
   parameter int unsigned S_WIDTH   = DEF_S_WIDTH,
   parameter int unsigned CNT_WIDTH = 12,
   parameter int unsigned LOCK_CNT  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 fdiv,
   output logic [CNT_WIDTH-1:0] period,
   output logic [P_WIDTH-1:0]   p_out,
   output logic [S_WIDTH-1:0]   s_out,
   output logic                 valid,
   output logic                 dec_err,
   output logic                 ovf,
   output logic                 locked
);

   localparam int unsigned        MATCH_W   = $clog2(LOCK_CNT + 1);
   localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);

   meter_state_t         state;
   logic                 rise;
   logic                 cnt_max;
   logic                 cnt_clr;
   logic                 cnt_load;
   logic                 cnt_inc;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] p_full;
   logic                 p_fits;
   logic [P_WIDTH-1:0]   p_dec;
   logic [MATCH_W-1:0]   match;
   logic [MATCH_W-1:0]   match_next;

   edge_period_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .fdiv    (fdiv),
      .clr     (cnt_clr),
      .load    (cnt_load),
      .inc     (cnt_inc),
      .rise    (rise),
      .cnt     (cnt),
      .cnt_max (cnt_max)
   );

   always_comb begin
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      if (!en) begin
         cnt_clr = 1'b1;
      end else begin
         case (state)
            ST_ARM:     cnt_load = rise;
            ST_MEASURE: begin
               cnt_load = rise;
               cnt_inc  = !rise;
            end
            default: ;
         endcase
      end
   end

   // Decode and lock compare act on the count being captured this edge
   always_comb begin
      p_full = cnt >> S_WIDTH;
      p_fits = (p_full >> P_WIDTH) == '0;
      p_dec  = p_fits ? p_full[P_WIDTH-1:0] : '1;
      if (cnt == period)
         match_next = (match == MATCH_MAX) ? match : match + MATCH_W'(1);
      else
         match_next = MATCH_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         period  <= '0;
         p_out   <= '0;
         s_out   <= '0;
         valid   <= 1'b0;
         dec_err <= 1'b0;
         ovf     <= 1'b0;
         locked  <= 1'b0;
         match   <= '0;
      end else begin
         valid <= 1'b0;
         if (!en) begin
            state  <= ST_IDLE;
            locked <= 1'b0;
            match  <= '0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_ARM;
               ST_ARM: begin
                  if (rise)
                     state <= ST_MEASURE;
               end
               ST_MEASURE: begin
                  // A rise coinciding with a full counter still yields a period
                  if (rise) begin
                     period  <= cnt;
                     p_out   <= p_dec;
                     s_out   <= cnt[S_WIDTH-1:0];
                     dec_err <= !p_fits;
                     valid   <= 1'b1;
                     ovf     <= 1'b0;
                     match   <= match_next;
                     locked  <= (match_next == MATCH_MAX);
                  end else if (cnt_max) begin
                     state  <= ST_OVF;
                     ovf    <= 1'b1;
                     locked <= 1'b0;
                     match  <= '0;
                  end
               end
               ST_OVF: state <= ST_ARM;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_period_meter.sv
// Randomised and directed bench for div_period_meter; expectations come from
// fdiv edge timestamps recorded by the stimulus driver.
module tb_div_period_meter;
   import frac_div_pkg::*;

   localparam int unsigned P_W  = 5;
   localparam int unsigned S_W  = 3;
   localparam int unsigned CW   = 12;
   localparam int unsigned LOCK = 4;

   logic          clk = 1'b0;
   logic          rst, en, fdiv;
   logic [CW-1:0] period;
   logic [P_W-1:0] p_out;
   logic [S_W-1:0] s_out;
   logic          valid, dec_err, ovf, locked;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;

   typedef struct {
      int unsigned per; int unsigned p; int unsigned s;
      bit err; bit lck; bit ov; int unsigned at;
   } obs_t;
   typedef struct { int unsigned per; int unsigned at; } exp_t;

   obs_t obs_q[$];
   exp_t exp_q[$];
   bit          armed = 1'b0;
   int unsigned last_rise = 0;
   int unsigned ref_last = 0;
   int unsigned ref_match = 0;

   div_period_meter #(
      .P_WIDTH   (P_W),
      .S_WIDTH   (S_W),
      .CNT_WIDTH (CW),
      .LOCK_CNT  (LOCK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .fdiv    (fdiv),
      .period  (period),
      .p_out   (p_out),
      .s_out   (s_out),
      .valid   (valid),
      .dec_err (dec_err),
      .ovf     (ovf),
      .locked  (locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (valid) obs_q.push_back('{period, p_out, s_out, dec_err, locked, ovf, cyc});

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record a rising edge about to be sampled at the next clk edge
   task automatic note_rise();
      int unsigned e;
      e = cyc + 1;
      if (armed) exp_q.push_back('{e - last_rise, e});
      armed = 1'b1;
      last_rise = e;
   endtask

   task automatic run_periods(input int unsigned n, input int unsigned k);
      for (int unsigned j = 0; j < k; j++)
         for (int unsigned i = 0; i < n; i++) begin
            fdiv = (i < n / 2);
            if (i == 0) note_rise();
            tick();
         end
   endtask

   task automatic check_stream(input string name);
      obs_t o;
      exp_t x;
      int unsigned q, ep, es;
      bit ee, el;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s valid_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         x = exp_q.pop_front();
         q  = x.per / (2 ** S_W);
         es = x.per % (2 ** S_W);
         ee = (q > (2 ** P_W) - 1);
         ep = ee ? (2 ** P_W) - 1 : q;
         if (x.per == ref_last) begin
            if (ref_match < LOCK) ref_match++;
         end else begin
            ref_match = 1;
         end
         ref_last = x.per;
         el = (ref_match == LOCK);
         checks++;
         if (o.per !== x.per) begin
            errors++;
            $display("FAIL %s period: got %0d expected %0d", name, o.per, x.per);
         end
         checks++;
         if (o.p !== ep || o.s !== es || o.err !== ee) begin
            errors++;
            $display("FAIL %s decode: got p=%0d s=%0d err=%0d expected p=%0d s=%0d err=%0d",
                     name, o.p, o.s, o.err, ep, es, ee);
         end
         checks++;
         if (o.lck !== el) begin
            errors++;
            $display("FAIL %s locked: got %0d expected %0d (period %0d)", name, o.lck, el, x.per);
         end
         checks++;
         if (o.at !== x.at) begin
            errors++;
            $display("FAIL %s valid_timing: got cycle %0d expected %0d", name, o.at, x.at);
         end
         checks++;
         if (o.ov !== 1'b0) begin
            errors++;
            $display("FAIL %s ovf_at_valid: got %0d expected 0", name, o.ov);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; fdiv = 1'b0;
      repeat (3) tick();
      checks++;
      if ({period, p_out, s_out, valid, dec_err, ovf, locked} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {period, p_out, s_out, valid, dec_err, ovf, locked});
      end
      rst = 1'b0;
      repeat (4) tick();
      check_stream("disabled");
   endtask

   task automatic test_lock();
      en = 1'b1;
      tick(); tick();
      run_periods(ratio_encode(16, 4), 6);
      check_stream("lock132");
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL lock132_held: got %0d expected 1", locked);
      end
   endtask

   task automatic test_ratio_change();
      run_periods(ratio_encode(16, 5), 5);
      check_stream("ratio133");
      checks++;
      if ({locked, p_out, s_out} !== {1'b1, 5'd16, 3'd5}) begin
         errors++;
         $display("FAIL ratio133_final: got locked=%0d p=%0d s=%0d expected 1 16 5", locked, p_out, s_out);
      end
   endtask

   task automatic test_ovf();
      int unsigned r;
      fdiv = 1'b1;
      note_rise();
      r = last_rise;
      tick();
      while (cyc < r + 4094) tick();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_early: got %0d expected 0 at cnt 4094", ovf);
      end
      tick();
      checks++;
      if ({ovf, locked, valid} !== 3'b100) begin
         errors++;
         $display("FAIL ovf_set: got ovf=%0d locked=%0d valid=%0d expected 1 0 0", ovf, locked, valid);
      end
      check_stream("ovf_stuck");
      armed = 1'b0;
      ref_match = 0;
      fdiv = 1'b0;
      repeat (10) tick();
      run_periods(20, 3);
      check_stream("ovf_resume");
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_cleared: got %0d expected 0", ovf);
      end
   endtask

   task automatic test_dec_err();
      run_periods(300, 3);
      check_stream("dec_err300");
      checks++;
      if ({p_out, s_out, dec_err} !== {5'd31, 3'd4, 1'b1}) begin
         errors++;
         $display("FAIL dec_err300_final: got p=%0d s=%0d err=%0d expected 31 4 1", p_out, s_out, dec_err);
      end
   endtask

   task automatic test_random();
      for (int unsigned seg = 0; seg < 8; seg++) begin
         run_periods($urandom_range(400, 2), $urandom_range(5, 1));
         check_stream("random");
      end
   endtask

   task automatic test_rst_mid();
      run_periods(132, 3);
      for (int unsigned i = 0; i < 100; i++) begin
         fdiv = (i < 66);
         if (i == 0) note_rise();
         tick();
      end
      check_stream("pre_rst");
      rst = 1'b1;
      tick();
      checks++;
      if ({period, p_out, s_out, valid, dec_err, ovf, locked} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %h expected 0",
                  {period, p_out, s_out, valid, dec_err, ovf, locked});
      end
      rst = 1'b0;
      armed = 1'b0; ref_match = 0; ref_last = 0;
      repeat (32) tick();
      run_periods(132, 5);
      check_stream("rst_restart");
   endtask

   task automatic test_fast_and_disable();
      run_periods(2, 10);
      check_stream("period2");
      en = 1'b0;
      fdiv = 1'b0;
      armed = 1'b0; ref_match = 0;
      tick(); tick();
      checks++;
      if ({locked, valid} !== 2'b00) begin
         errors++;
         $display("FAIL disable_lock: got locked=%0d valid=%0d expected 0 0", locked, valid);
      end
      checks++;
      if (period !== 12'd2 || p_out !== 5'd0 || s_out !== 3'd2) begin
         errors++;
         $display("FAIL disable_hold: got period=%0d p=%0d s=%0d expected 2 0 2", period, p_out, s_out);
      end
      repeat (5) tick();
      check_stream("disabled_idle");
   endtask

   initial begin
      test_reset();
      test_lock();
      test_ratio_change();
      test_ovf();
      test_dec_err();
      test_random();
      test_rst_mid();
      test_fast_and_disable();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
